seg7_scan_decoder: RTL
======================

# seg7_scan_decoder

Receive-side counterpart of the team's multiplexed 4-digit seven-segment display driver. It watches the scanned segment and anode lines and reconstructs the 16-bit hex value being shown. After all four digits are captured it publishes the value with a one-cycle `valid` strobe. It sits on board-level loopback/observation nets and serves as a self-check monitor for display paths and as a capture block for external scanned displays.

## Interface
- `STABLE_CYCLES`, default 2: consecutive identical synchronized samples required before a digit is captured (legal range 1..255).
- `TIMEOUT_CYCLES`, default 1024: idle cycles without a capture before `stale` asserts. Used only with `SEG7_SCAN_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `seg_in` in 7: segment lines, active-low, bit0=a … bit6=g.
- `an_in` in 4: anode select, active-high one-hot. `an_in[0]` selects `value[15:12]`; `an_in[3]` selects `value[3:0]`.
- `value` out 16: last complete frame.
- `valid` out 1: one-cycle pulse when `value` updates.
- `seg_err` out 1: at least one unrecognised pattern occurred in the current or just-completed frame.
- `stale` out 1: no capture for `TIMEOUT_CYCLES` cycles.

## Operation
- `seg_in` and `an_in` each pass through a 2-flop synchronizer. The combined 11-bit pair is then compared with its value on the previous cycle.
- Two-state FSM:
  - SETTLE: the stability counter increments while the pair is unchanged and reloads to 1 on any change. When the counter reaches `STABLE_CYCLES`, the digit is captured and the FSM moves to HOLD.
  - HOLD: wait until the pair changes, then reload the counter to 1 and return to SETTLE. This guarantees exactly one capture per dwell.
- Capture rules:
  - `an_in` not one-hot (0000 or multiple bits set): blanking. No capture, no error, seen bits untouched.
  - One-hot `an_in` with a valid pattern: write the nibble into the selected slot and set its seen bit.
  - One-hot `an_in` with an invalid pattern (anything outside the 16 codes): the slot is unchanged, its seen bit stays clear, and the sticky `seg_err_pend` bit is set.
- Valid patterns (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Frame completion:
  - When all 4 seen bits are set, the next edge loads `value` from the slots, pulses `valid`, copies `seg_err_pend` to `seg_err`, and clears the seen bits and `seg_err_pend`.
  - `seg_err` also asserts immediately whenever `seg_err_pend` sets.
- Digit order is irrelevant.
- Re-capturing an already-seen slot before frame completion overwrites that nibble; last value wins.

## Timing
- Reset values: `value`=16'h0000, `valid`=0, `seg_err`=0, `stale`=0. FSM in SETTLE, counter 0, seen bits 0, slots 0.
- Latency from a raw input change to capture is 2 + `STABLE_CYCLES` edges (default 4).
- `valid` rises on the edge after the capture that sets the 4th seen bit. `value` changes on that same edge.
- A capture and frame completion coincide only across consecutive edges. A capture on the completion edge goes into the new frame.
- A glitch shorter than `STABLE_CYCLES` is ignored and restarts the count.
- Asserting `rst_n` low mid-frame discards partial slots at once. No `valid` is produced for the interrupted frame.

## Configuration
- `SEG7_SCAN_TIMEOUT_EN` defined:
  - A counter counts cycles since the last capture, saturating at `TIMEOUT_CYCLES`.
  - `stale` is 1 while saturated and clears on the edge of the next capture.
  - Blanked or invalid dwells do not reset the counter.
- Not defined: no counter is built and `stale` is tied to 0.

## Structure
- Package `seg7_pkg`: the 16 segment pattern constants, the anode-to-slot index mapping, and the default parameter values.
- Sub-module `seg7_pattern_to_hex`: combinational 7-bit to {hit, nibble} reverse lookup. It is the inverse of the display encoder and reusable elsewhere.

## Test plan
- Scan 0→0001/1000000, D→0010/0100001, 8→0100/0000000, C→1000/1000110, each held 8 cycles -> `value`=16'h0D8C, one `valid` pulse, `seg_err`=0.
- Same frame, but one dwell shows 1111001 for 1 cycle before the correct pattern with `STABLE_CYCLES`=2 -> glitch ignored, `value`=16'h0D8C.
- Digit 2 shows 1111111 (blank) with `an_in`=0100 -> no `valid` until a correct 8 is seen. `seg_err`=1 immediately and held through the completed frame, then 0 after a clean frame.
- `an_in`=0000 and 0011 inserted between dwells -> no effect on slots or errors.
- `rst_n` pulsed low after 2 of 4 digits -> all outputs 0. The next full frame F,E,E,D gives 16'hFEED with exactly one `valid`.
- With `SEG7_SCAN_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, inputs frozen 20 cycles after a capture -> `stale`=1 from cycle 16. A new digit dwell clears `stale` on its capture edge.

Source files
------------

// File: rtl/seg7_scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// seg7_pkg : shared constants for the scanned seven-segment capture path
//            (segment codes, anode-to-slot mapping, default parameters).
// Revision  : 1.0
// ============================================================================
package seg7_pkg;

    localparam int STABLE_CYCLES_DEFAULT  = 2;
    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

    // Active-low segment codes, bit order gfedcba.
    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    localparam logic [15:0][6:0] SEG_HEX_TABLE = {
        SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
        SEG_HEX_B, SEG_HEX_A, SEG_HEX_9, SEG_HEX_8,
        SEG_HEX_7, SEG_HEX_6, SEG_HEX_5, SEG_HEX_4,
        SEG_HEX_3, SEG_HEX_2, SEG_HEX_1, SEG_HEX_0
    };

    typedef logic [0:0] scan_state_t;
    localparam scan_state_t ST_SETTLE = 1'b0;
    localparam scan_state_t ST_HOLD   = 1'b1;

    function automatic logic an_is_onehot(input logic [3:0] an);
        return $onehot(an);
    endfunction

    // Slot 0 is the leftmost digit, i.e. value[15:12].
    function automatic logic [1:0] an_to_slot(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// seg7_scan_decoder_if : scanned display lines in, reconstructed frame out.
// Revision  : 1.0
// ============================================================================
interface seg7_scan_decoder_if;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] value;
    logic        valid;
    logic        seg_err;
    logic        stale;

    modport master (
        output seg_in, an_in,
        input  value, valid, seg_err, stale
    );

    modport slave (
        input  seg_in, an_in,
        output value, valid, seg_err, stale
    );
endinterface
`default_nettype wire

// File: rtl/seg7_pattern_to_hex.sv
`default_nettype none
// ============================================================================
// seg7_pattern_to_hex : reverse lookup of an active-low segment code to its
//                       hex nibble; hit is low for unrecognised patterns.
// Revision  : 1.0
// ============================================================================
module seg7_pattern_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX_TABLE[i]) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// seg7_scan_decoder : rebuilds the 16-bit value shown on a scanned 4-digit
//                     display. Optional idle watchdog: SEG7_SCAN_TIMEOUT_EN.
// Revision  : 1.0
// ============================================================================
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = STABLE_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_decoder_if.slave bus
);

    localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

    logic [6:0]       seg_meta, seg_sync;
    logic [3:0]       an_meta, an_sync;
    logic [10:0]      pair, pair_prev;
    logic             pair_changed;
    scan_state_t      state, state_next;
    logic [7:0]       stab_cnt, stab_cnt_next;
    logic             capture;
    logic             pat_hit;
    logic [3:0]       pat_nibble;
    logic             an_onehot;
    logic [1:0]       slot_idx;
    logic             capture_ok, capture_bad;
    logic [3:0][3:0]  slots;
    logic [3:0]       seen;
    logic             frame_done;
    logic             err_pend;
    logic [15:0]      value_q;
    logic             valid_q;
    logic             seg_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta  <= '0;
            seg_sync  <= '0;
            an_meta   <= '0;
            an_sync   <= '0;
            pair_prev <= '0;
        end else begin
            seg_meta  <= bus.seg_in;
            seg_sync  <= seg_meta;
            an_meta   <= bus.an_in;
            an_sync   <= an_meta;
            pair_prev <= pair;
        end
    end

    assign pair         = {an_sync, seg_sync};
    assign pair_changed = (pair != pair_prev);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_SETTLE;
            stab_cnt <= '0;
        end else begin
            state    <= state_next;
            stab_cnt <= stab_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_SETTLE: if (capture) state_next = ST_HOLD;
            ST_HOLD:   if (pair_changed && !capture) state_next = ST_SETTLE;
            default:   state_next = ST_SETTLE;
        endcase
    end

    // A change seen in HOLD reloads the counter; with STABLE_CYCLES=1 that
    // reload already completes the dwell, so the capture happens there.
    always_comb begin
        stab_cnt_next = stab_cnt;
        capture       = 1'b0;
        if ((state == ST_SETTLE) || pair_changed) begin
            stab_cnt_next = pair_changed ? 8'd1 : (stab_cnt + 8'd1);
            capture       = (stab_cnt_next == STABLE_LIMIT);
        end
    end

    seg7_pattern_to_hex u_pattern_to_hex (
        .seg    (seg_sync),
        .hit    (pat_hit),
        .nibble (pat_nibble)
    );

    assign an_onehot   = an_is_onehot(an_sync);
    assign slot_idx    = an_to_slot(an_sync);
    assign capture_ok  = capture && an_onehot && pat_hit;
    assign capture_bad = capture && an_onehot && !pat_hit;
    assign frame_done  = &seen;

    // A capture landing on the completion edge belongs to the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots     <= '0;
            seen      <= '0;
            err_pend  <= 1'b0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            seg_err_q <= 1'b0;
        end else begin
            valid_q  <= frame_done;
            if (frame_done) begin
                value_q <= {slots[0], slots[1], slots[2], slots[3]};
            end
            if (capture_ok) begin
                slots[slot_idx] <= pat_nibble;
            end
            seen     <= (frame_done ? 4'b0000 : seen)
                      | (capture_ok ? (4'b0001 << slot_idx) : 4'b0000);
            err_pend <= (frame_done ? 1'b0 : err_pend) | capture_bad;
            if (capture_bad) begin
                seg_err_q <= 1'b1;
            end else if (frame_done) begin
                seg_err_q <= err_pend;
            end
        end
    end

    assign bus.value   = value_q;
    assign bus.valid   = valid_q;
    assign bus.seg_err = seg_err_q;

`ifdef SEG7_SCAN_TIMEOUT_EN
    localparam int                IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_cnt;

    // Only good captures count as activity; blanking and bad codes do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (capture_ok) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign bus.stale = (idle_cnt == IDLE_MAX);
`else
    assign bus.stale = 1'b0;
`endif

endmodule
`default_nettype wire
